// File: rtl/bus_master_if_pkg.sv
// Shared types and constants for the bus master interface unit.
package bus_master_if_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    // Read/write encoding used on cpu_rw and bus_rw.
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Active-low strobe levels.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int BUS_IF_STATE_W = 2;

    typedef enum logic [BUS_IF_STATE_W-1:0] {
        BUS_IF_IDLE   = 2'd0,
        BUS_IF_REQ    = 2'd1,
        BUS_IF_ACCESS = 2'd2
    } bus_if_state_e;

endpackage

// File: rtl/bus_master_if.sv
// Master-side bus interface: takes one single-word request from a master
// core, arbitrates for the bus, performs the access and reports done/err.
//
// Handshakes: the core presents a request by driving cpu_as_ low while
// cpu_busy is low (or in the cycle cpu_done/cpu_err is high); the request is
// taken on that clock edge and cpu_busy stays high until completion, during
// which further cpu_as_ pulses are dropped. Towards the arbiter bus_req_ is
// held low until bus_grnt_ is seen low; the slave ends the access by pulling
// bus_rdy_ low at a clock edge while the address phase is held stable.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_as_,
    input  logic                   cpu_rw,
    input  logic [WORD_ADDR_W-1:0] cpu_addr,
    input  logic [WORD_DATA_W-1:0] cpu_wr_data,
    output logic                   cpu_busy,
    output logic                   cpu_done,
    output logic                   cpu_err,
    output logic [WORD_DATA_W-1:0] cpu_rd_data,
    output logic                   bus_req_,
    input  logic                   bus_grnt_,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy_,
    output logic [BUS_IF_STATE_W-1:0] dbg_state
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_if_state_e state, state_nxt;

    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   lat_rw;
    logic [WORD_ADDR_W-1:0] lat_addr;
    logic [WORD_DATA_W-1:0] lat_wr_data;
    logic                   latch_en;

    logic                   req_nxt, as_nxt, rw_nxt, done_nxt, err_nxt;
    logic [WORD_ADDR_W-1:0] addr_nxt;
    logic [WORD_DATA_W-1:0] wd_nxt, rd_nxt;

    assign dbg_state = state;

    // Busy covers the accept cycle combinationally; otherwise any non-idle state.
    assign cpu_busy = (state == BUS_IF_IDLE) ? ~cpu_as_ : 1'b1;

    // State, registered outputs, timeout counter and request latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BUS_IF_IDLE;
            cnt         <= '0;
            lat_rw      <= READ;
            lat_addr    <= '0;
            lat_wr_data <= '0;
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_rw      <= READ;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            cpu_done    <= 1'b0;
            cpu_err     <= 1'b0;
            cpu_rd_data <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bus_req_    <= req_nxt;
            bus_as_     <= as_nxt;
            bus_rw      <= rw_nxt;
            bus_addr    <= addr_nxt;
            bus_wr_data <= wd_nxt;
            cpu_done    <= done_nxt;
            cpu_err     <= err_nxt;
            cpu_rd_data <= rd_nxt;
            if (latch_en) begin
                lat_rw      <= cpu_rw;
                lat_addr    <= cpu_addr;
                lat_wr_data <= cpu_wr_data;
            end
        end
    end

    // Next-state and next-output decode; release returns the bus to idle values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_en  = 1'b0;
        req_nxt   = bus_req_;
        as_nxt    = DISABLE_;
        rw_nxt    = bus_rw;
        addr_nxt  = bus_addr;
        wd_nxt    = bus_wr_data;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        rd_nxt    = cpu_rd_data;

        unique case (state)
            BUS_IF_IDLE: begin
                if (cpu_as_ == ENABLE_) begin
                    latch_en  = 1'b1;
                    req_nxt   = ENABLE_;
                    state_nxt = BUS_IF_REQ;
                end
            end
            BUS_IF_REQ: begin
                req_nxt = ENABLE_;
                if (bus_grnt_ == ENABLE_) begin
                    addr_nxt  = lat_addr;
                    rw_nxt    = lat_rw;
                    wd_nxt    = lat_wr_data;
                    as_nxt    = ENABLE_;
                    cnt_nxt   = '0;
                    state_nxt = BUS_IF_ACCESS;
                end
            end
            BUS_IF_ACCESS: begin
                // Slave ready takes priority over lost grant and timeout.
                if ((bus_rdy_ == ENABLE_) || (bus_grnt_ == DISABLE_) || (cnt == CNT_LAST)) begin
                    if (bus_rdy_ == ENABLE_) begin
                        done_nxt = 1'b1;
                        if (bus_rw == READ) begin
                            rd_nxt = bus_rd_data;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                    req_nxt   = DISABLE_;
                    addr_nxt  = '0;
                    rw_nxt    = READ;
                    wd_nxt    = '0;
                    state_nxt = BUS_IF_IDLE;
                end else if (cnt != CNT_LAST) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = BUS_IF_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if with a TIMEOUT of 4.
module tb_bus_master_if;
    import bus_master_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_as_;
    logic        cpu_rw;
    logic [29:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rd_data;
    logic        bus_req_;
    logic        bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    bus_master_if #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_as_     (cpu_as_),
        .cpu_rw      (cpu_rw),
        .cpu_addr    (cpu_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_busy    (cpu_busy),
        .cpu_done    (cpu_done),
        .cpu_err     (cpu_err),
        .cpu_rd_data (cpu_rd_data),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_),
        .dbg_state   (dbg_state)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus outputs at their idle/reset values.
    task automatic chk_bus_idle(input string tag);
        chk({tag, "_req"},  32'(bus_req_), 32'h1);
        chk({tag, "_as"},   32'(bus_as_), 32'h1);
        chk({tag, "_rw"},   32'(bus_rw), 32'h1);
        chk({tag, "_addr"}, 32'(bus_addr), 32'h0);
        chk({tag, "_wd"},   32'(bus_wr_data), 32'h0);
    endtask

    task automatic request(input logic rw, input logic [29:0] addr, input logic [31:0] wd);
        cpu_as_     = 1'b0;
        cpu_rw      = rw;
        cpu_addr    = addr;
        cpu_wr_data = wd;
    endtask

    initial begin
        rst         = 1'b0;
        cpu_as_     = 1'b1;
        cpu_rw      = 1'b1;
        cpu_addr    = '0;
        cpu_wr_data = '0;
        bus_grnt_   = 1'b1;
        bus_rd_data = '0;
        bus_rdy_    = 1'b1;

        // Reset state.
        tick();
        tick();
        chk_bus_idle("rst");
        chk("rst_done", 32'(cpu_done), 32'h0);
        chk("rst_err", 32'(cpu_err), 32'h0);
        chk("rst_rd", cpu_rd_data, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
        chk("rst_busy", 32'(cpu_busy), 32'h0);
        rst = 1'b1;
        tick();

        // Read, immediate grant, combinational slave.
        request(1'b1, 30'h10, 32'h0);
        bus_grnt_   = 1'b0;
        bus_rdy_    = 1'b0;
        bus_rd_data = 32'hDEADBEEF;
        #1;
        chk("rd_busy_accept", 32'(cpu_busy), 32'h1);
        tick();
        cpu_as_ = 1'b1;
        chk("rd_c1_req", 32'(bus_req_), 32'h0);
        chk("rd_c1_as", 32'(bus_as_), 32'h1);
        chk("rd_c1_addr", 32'(bus_addr), 32'h0);
        chk("rd_c1_state", 32'(dbg_state), 32'h1);
        tick();
        chk("rd_c2_as", 32'(bus_as_), 32'h0);
        chk("rd_c2_addr", 32'(bus_addr), 32'h10);
        chk("rd_c2_rw", 32'(bus_rw), 32'h1);
        chk("rd_c2_done", 32'(cpu_done), 32'h0);
        chk("rd_c2_busy", 32'(cpu_busy), 32'h1);
        tick();
        chk("rd_c3_done", 32'(cpu_done), 32'h1);
        chk("rd_c3_data", cpu_rd_data, 32'hDEADBEEF);
        chk_bus_idle("rd_c3");
        chk("rd_c3_busy", 32'(cpu_busy), 32'h0);
        bus_grnt_ = 1'b1;
        bus_rdy_  = 1'b1;
        tick();
        chk("rd_c4_done", 32'(cpu_done), 32'h0);

        // Write with grant delayed by another master.
        request(1'b0, 30'h0000_0100, 32'h1234_5678);
        tick();
        cpu_as_ = 1'b1;
        chk("wr_req", 32'(bus_req_), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_wait_addr", 32'(bus_addr), 32'h0);
            chk("wr_wait_wd", bus_wr_data, 32'h0);
            chk("wr_wait_as", 32'(bus_as_), 32'h1);
            chk("wr_wait_state", 32'(dbg_state), 32'h1);
        end
        bus_grnt_ = 1'b0;
        tick();
        chk("wr_acc_as", 32'(bus_as_), 32'h0);
        chk("wr_acc_addr", 32'(bus_addr), 32'h100);
        chk("wr_acc_wd", bus_wr_data, 32'h1234_5678);
        chk("wr_acc_rw", 32'(bus_rw), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("wr_hold_as", 32'(bus_as_), 32'h1);
            chk("wr_hold_addr", 32'(bus_addr), 32'h100);
            chk("wr_hold_wd", bus_wr_data, 32'h1234_5678);
            chk("wr_hold_done", 32'(cpu_done), 32'h0);
        end
        bus_rdy_ = 1'b0;
        tick();
        chk("wr_done", 32'(cpu_done), 32'h1);
        chk("wr_rd_keep", cpu_rd_data, 32'hDEADBEEF);
        chk_bus_idle("wr_rel");
        bus_rdy_ = 1'b1;
        tick();

        // Timeout with a slave that never answers.
        request(1'b1, 30'h200, 32'h0);
        bus_grnt_   = 1'b0;
        bus_rd_data = 32'hBAD0BAD0;
        tick();
        cpu_as_ = 1'b1;
        tick();
        chk("to_entry_state", 32'(dbg_state), 32'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_err", 32'(cpu_err), 32'h0);
            chk("to_wait_state", 32'(dbg_state), 32'h2);
        end
        tick();
        chk("to_err", 32'(cpu_err), 32'h1);
        chk("to_done", 32'(cpu_done), 32'h0);
        chk("to_rd_keep", cpu_rd_data, 32'hDEADBEEF);
        chk_bus_idle("to_rel");
        tick();
        chk("to_err_pulse", 32'(cpu_err), 32'h0);

        // Back-to-back requests, and a strobe during REQ is dropped.
        request(1'b1, 30'h20, 32'h0);
        bus_rdy_    = 1'b0;
        bus_rd_data = 32'h1111_2222;
        tick();
        cpu_as_ = 1'b1;
        tick();
        tick();
        chk("b2b_done1", 32'(cpu_done), 32'h1);
        chk("b2b_data1", cpu_rd_data, 32'h1111_2222);
        request(1'b1, 30'h30, 32'h0);
        bus_grnt_   = 1'b1;
        bus_rd_data = 32'h3333_4444;
        #1;
        chk("b2b_busy", 32'(cpu_busy), 32'h1);
        tick();
        chk("b2b_req", 32'(bus_req_), 32'h0);
        chk("b2b_state", 32'(dbg_state), 32'h1);
        cpu_as_  = 1'b0;
        cpu_addr = 30'h3F;
        tick();
        cpu_as_ = 1'b1;
        chk("b2b_req_hold", 32'(dbg_state), 32'h1);
        bus_grnt_ = 1'b0;
        tick();
        chk("b2b_addr", 32'(bus_addr), 32'h30);
        tick();
        chk("b2b_done2", 32'(cpu_done), 32'h1);
        chk("b2b_data2", cpu_rd_data, 32'h3333_4444);
        tick();
        chk("b2b_no_queue_state", 32'(dbg_state), 32'h0);
        chk("b2b_no_queue_req", 32'(bus_req_), 32'h1);
        bus_rdy_ = 1'b1;

        // Grant withdrawn during ACCESS.
        request(1'b1, 30'h50, 32'h0);
        bus_rd_data = 32'h5555_6666;
        tick();
        cpu_as_ = 1'b1;
        tick();
        bus_grnt_ = 1'b1;
        tick();
        chk("gl_err", 32'(cpu_err), 32'h1);
        chk("gl_done", 32'(cpu_done), 32'h0);
        chk("gl_rd_keep", cpu_rd_data, 32'h3333_4444);
        chk_bus_idle("gl_rel");

        // Grant withdrawn together with slave ready: ready wins.
        request(1'b1, 30'h60, 32'h0);
        bus_grnt_   = 1'b0;
        bus_rd_data = 32'h7777_8888;
        tick();
        cpu_as_ = 1'b1;
        tick();
        bus_grnt_ = 1'b1;
        bus_rdy_  = 1'b0;
        tick();
        chk("glr_done", 32'(cpu_done), 32'h1);
        chk("glr_err", 32'(cpu_err), 32'h0);
        chk("glr_data", cpu_rd_data, 32'h7777_8888);
        bus_rdy_ = 1'b1;
        tick();

        // Asynchronous reset in the middle of ACCESS.
        request(1'b0, 30'h40, 32'hCAFE_F00D);
        bus_grnt_ = 1'b0;
        tick();
        cpu_as_ = 1'b1;
        tick();
        chk("ar_acc_as", 32'(bus_as_), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk_bus_idle("ar_async");
        chk("ar_rd", cpu_rd_data, 32'h0);
        chk("ar_state", 32'(dbg_state), 32'h0);
        tick();
        chk("ar_done", 32'(cpu_done), 32'h0);
        chk("ar_err", 32'(cpu_err), 32'h0);
        rst = 1'b1;
        tick();
        chk("ar_post_done", 32'(cpu_done), 32'h0);
        chk("ar_post_err", 32'(cpu_err), 32'h0);

        // Normal read after reset.
        request(1'b1, 30'h70, 32'h0);
        bus_rdy_    = 1'b0;
        bus_rd_data = 32'h0BAD_CAFE;
        tick();
        cpu_as_ = 1'b1;
        tick();
        chk("pr_addr", 32'(bus_addr), 32'h70);
        tick();
        chk("pr_done", 32'(cpu_done), 32'h1);
        chk("pr_data", cpu_rd_data, 32'h0BAD_CAFE);
        bus_rdy_ = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
